// File: rtl/ram_pkg.sv
// Shared types and constants for the exec-unit RAM responder.
// Holds the posted-write entry layout and word-addressing constants.
package ram_pkg;

  localparam int RAM_AW     = 14;
  localparam int WORD_BYTES = 4;
  localparam int ADDR_LSB   = 2;

  typedef struct packed {
    logic [RAM_AW-1:0] idx;
    logic [31:0]       data;
  } wb_entry_t;

endpackage

// File: rtl/ram_write_buffer.sv
// Circular posted-write FIFO with youngest-match read lookup.
// Ports: push/push_entry in, pop in, head/count/full/empty out, lk_* lookup.
module ram_write_buffer
  import ram_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int CW = $clog2(DEPTH + 1),
  localparam int PW = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              push,
  input  wb_entry_t         push_entry,
  input  logic              pop,
  output wb_entry_t         head,
  output logic [CW-1:0]     count,
  output logic              full,
  output logic              empty,
  input  logic [RAM_AW-1:0] lk_idx,
  output logic              lk_hit,
  output logic [31:0]       lk_data
);

  wb_entry_t       ent [DEPTH];
  logic [PW-1:0]   wr_ptr;
  logic [PW-1:0]   rd_ptr;
  logic [PW-1:0]   slot;

  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);
  assign head  = ent[rd_ptr];

  always_ff @(posedge clk) begin
    if (push) ent[wr_ptr] <= push_entry;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      unique case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Walk oldest to youngest; a later match overrides an earlier one.
  always_comb begin
    lk_hit  = 1'b0;
    lk_data = '0;
    slot    = '0;
    for (int i = 0; i < DEPTH; i++) begin
      slot = rd_ptr + PW'(i);
      if ((CW'(i) < count) && (ent[slot].idx == lk_idx)) begin
        lk_hit  = 1'b1;
        lk_data = ent[slot].data;
      end
    end
  end

endmodule

// File: rtl/ram_responder.sv
// Single-port word RAM serving rd_ram_*/wr_ram_* with posted writes.
// Ports: clk, reset_n, rd_ram_en/addr/data/valid, wr_ram_en/addr/data, wb_count, wb_full.
module ram_responder
  import ram_pkg::*;
#(
  parameter int    AW        = RAM_AW,
  parameter int    WB_DEPTH  = 4,
  parameter string INIT_FILE = "",
  localparam int CW = $clog2(WB_DEPTH + 1)
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          rd_ram_en,
  input  logic [15:0]   rd_ram_addr,
  output logic [31:0]   rd_ram_data,
  output logic          rd_ram_valid,
  input  logic          wr_ram_en,
  input  logic [31:0]   wr_ram_addr,
  input  logic [31:0]   wr_ram_data,
  output logic [CW-1:0] wb_count,
  output logic          wb_full
);

  logic [31:0]   mem [2**AW];
  logic [31:0]   ram_q;
  logic [AW-1:0] rd_idx;
  logic [AW-1:0] wr_idx;
  logic [AW-1:0] ram_addr;

  wb_entry_t     push_entry;
  wb_entry_t     head;
  logic          wb_empty;
  logic          lk_hit;
  logic [31:0]   lk_data;

  logic          pop;
  logic          fwd;
  logic          arr_rd;

  logic          rsp_arr_q;
  logic [31:0]   data_q;

  logic          unused;
  assign unused = ^{wr_ram_addr[31:AW+2], wr_ram_addr[1:0], rd_ram_addr[1:0]};

  assign rd_idx = rd_ram_addr[AW+1:ADDR_LSB];
  assign wr_idx = wr_ram_addr[AW+1:ADDR_LSB];

  assign push_entry.idx  = RAM_AW'(wr_idx);
  assign push_entry.data = wr_ram_data;

  ram_write_buffer #(
    .DEPTH      (WB_DEPTH)
  ) u_wb (
    .clk        (clk),
    .reset_n    (reset_n),
    .push       (wr_ram_en),
    .push_entry (push_entry),
    .pop        (pop),
    .head       (head),
    .count      (wb_count),
    .full       (wb_full),
    .empty      (wb_empty),
    .lk_idx     (RAM_AW'(rd_idx)),
    .lk_hit     (lk_hit),
    .lk_data    (lk_data)
  );

  // A full buffer always drains, so a same-cycle push cannot overflow.
  always_comb begin
    fwd      = rd_ram_en && lk_hit;
    arr_rd   = rd_ram_en && !lk_hit && !wb_full;
    pop      = wb_full || (!rd_ram_en && !wb_empty);
    ram_addr = pop ? AW'(head.idx) : rd_idx;
  end

  always_ff @(posedge clk) begin
    if (pop)    mem[ram_addr] <= head.data;
    if (arr_rd) ram_q <= mem[ram_addr];
  end

  // Output is ram_q after an array read, else the held/forwarded word.
  assign rd_ram_data = rsp_arr_q ? ram_q : data_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rsp_arr_q    <= 1'b0;
      data_q       <= '0;
      rd_ram_valid <= 1'b0;
    end else begin
      rd_ram_valid <= fwd || arr_rd;
      rsp_arr_q    <= arr_rd;
      if (fwd)         data_q <= lk_data;
      else if (!arr_rd) data_q <= rd_ram_data;
    end
  end

endmodule

// File: tb/tb_ram_responder.sv
// Directed table-driven bench for ram_responder.
// Each vector is one clock cycle of inputs plus expected post-edge outputs.
module tb_ram_responder;

  logic        clk;
  logic        reset_n;
  logic        rd_ram_en;
  logic [15:0] rd_ram_addr;
  logic [31:0] rd_ram_data;
  logic        rd_ram_valid;
  logic        wr_ram_en;
  logic [31:0] wr_ram_addr;
  logic [31:0] wr_ram_data;
  logic [2:0]  wb_count;
  logic        wb_full;

  int checks;
  int failures;

  ram_responder dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .rd_ram_en    (rd_ram_en),
    .rd_ram_addr  (rd_ram_addr),
    .rd_ram_data  (rd_ram_data),
    .rd_ram_valid (rd_ram_valid),
    .wr_ram_en    (wr_ram_en),
    .wr_ram_addr  (wr_ram_addr),
    .wr_ram_data  (wr_ram_data),
    .wb_count     (wb_count),
    .wb_full      (wb_full)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rd;
    logic [15:0] ra;
    logic        wr;
    logic [31:0] wa;
    logic [31:0] wd;
    logic        ev;
    logic [31:0] ed;
    logic [2:0]  ec;
  } vec_t;

  vec_t vq[$];

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic v(input logic rd, input logic [15:0] ra, input logic wr,
                   input logic [31:0] wa, input logic [31:0] wd,
                   input logic ev, input logic [31:0] ed, input logic [2:0] ec);
    vec_t t;
    t.rd = rd; t.ra = ra; t.wr = wr; t.wa = wa; t.wd = wd;
    t.ev = ev; t.ed = ed; t.ec = ec;
    vq.push_back(t);
  endtask

  task automatic idle_inputs();
    rd_ram_en   = 1'b0;
    rd_ram_addr = '0;
    wr_ram_en   = 1'b0;
    wr_ram_addr = '0;
    wr_ram_data = '0;
  endtask

  task automatic run_vecs();
    for (int i = 0; i < vq.size(); i++) begin
      rd_ram_en   = vq[i].rd;
      rd_ram_addr = vq[i].ra;
      wr_ram_en   = vq[i].wr;
      wr_ram_addr = vq[i].wa;
      wr_ram_data = vq[i].wd;
      @(posedge clk);
      #1;
      check($sformatf("v%0d valid", i), 32'(rd_ram_valid), 32'(vq[i].ev));
      check($sformatf("v%0d data", i), rd_ram_data, vq[i].ed);
      check($sformatf("v%0d count", i), 32'(wb_count), 32'(vq[i].ec));
      check($sformatf("v%0d full", i), 32'(wb_full), 32'(vq[i].ec == 3'd4));
    end
    vq.delete();
    idle_inputs();
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    reset_n  = 1'b0;
    idle_inputs();
    repeat (2) @(posedge clk);
    #1;
    check("rst valid", 32'(rd_ram_valid), 32'd0);
    check("rst data", rd_ram_data, 32'd0);
    check("rst count", 32'(wb_count), 32'd0);
    check("rst full", 32'(wb_full), 32'd0);
    reset_n = 1'b1;

    // rd ra wr wa wd | ev ed ec
    v(0, 16'h0000, 1, 32'h0000_000C, 32'hDEADBEEF, 0, 32'h0, 1);
    v(0, 16'h0000, 0, 32'h0, 32'h0, 0, 32'h0, 0);
    v(1, 16'h000C, 0, 32'h0, 32'h0, 1, 32'hDEADBEEF, 0);
    // forwarding and same-cycle RAW
    v(1, 16'h000C, 1, 32'h0000_0020, 32'h11, 1, 32'hDEADBEEF, 1);
    v(1, 16'h0020, 0, 32'h0, 32'h0, 1, 32'h11, 1);
    v(1, 16'h0020, 1, 32'h0000_0020, 32'h22, 1, 32'h11, 2);
    v(1, 16'h0020, 0, 32'h0, 32'h0, 1, 32'h22, 2);
    v(0, 16'h0000, 0, 32'h0, 32'h0, 0, 32'h22, 1);
    v(0, 16'h0000, 0, 32'h0, 32'h0, 0, 32'h22, 0);
    v(1, 16'h0020, 0, 32'h0, 32'h0, 1, 32'h22, 0);
    // fill buffer while reading
    v(1, 16'h000C, 1, 32'h0000_0100, 32'hA1, 1, 32'hDEADBEEF, 1);
    v(1, 16'h000C, 1, 32'h0000_0104, 32'hA2, 1, 32'hDEADBEEF, 2);
    v(1, 16'h000C, 1, 32'h0000_0108, 32'hA3, 1, 32'hDEADBEEF, 3);
    v(1, 16'h000C, 1, 32'h0000_010C, 32'hA4, 1, 32'hDEADBEEF, 4);
    v(1, 16'h000C, 0, 32'h0, 32'h0, 0, 32'hDEADBEEF, 3);
    v(1, 16'h000C, 0, 32'h0, 32'h0, 1, 32'hDEADBEEF, 3);
    v(1, 16'h000C, 1, 32'h0000_0110, 32'hA5, 1, 32'hDEADBEEF, 4);
    v(1, 16'h000C, 1, 32'h0000_0114, 32'hA6, 0, 32'hDEADBEEF, 4);
    v(1, 16'h0104, 0, 32'h0, 32'h0, 0, 32'hDEADBEEF, 3);
    v(1, 16'h0104, 0, 32'h0, 32'h0, 1, 32'hA2, 3);
    v(1, 16'h0110, 0, 32'h0, 32'h0, 1, 32'hA5, 3);
    v(1, 16'h000C, 1, 32'h0000_0118, 32'hA7, 1, 32'hDEADBEEF, 4);
    v(1, 16'h0114, 0, 32'h0, 32'h0, 1, 32'hA6, 3);
    v(0, 16'h0000, 0, 32'h0, 32'h0, 0, 32'hA6, 2);
    v(0, 16'h0000, 0, 32'h0, 32'h0, 0, 32'hA6, 1);
    v(0, 16'h0000, 0, 32'h0, 32'h0, 0, 32'hA6, 0);
    v(1, 16'h0118, 0, 32'h0, 32'h0, 1, 32'hA7, 0);
    v(1, 16'h0108, 0, 32'h0, 32'h0, 1, 32'hA3, 0);
    v(1, 16'h0100, 0, 32'h0, 32'h0, 1, 32'hA1, 0);
    v(1, 16'h010C, 0, 32'h0, 32'h0, 1, 32'hA4, 0);
    // same-address writes drain in order; upper address bits ignored
    v(0, 16'h0000, 1, 32'hFFFF_0040, 32'hA, 0, 32'hA4, 1);
    v(0, 16'h0000, 1, 32'h0000_0043, 32'hB, 0, 32'hA4, 1);
    v(0, 16'h0000, 0, 32'h0, 32'h0, 0, 32'hA4, 0);
    v(0, 16'h0000, 0, 32'h0, 32'h0, 0, 32'hA4, 0);
    v(0, 16'h0000, 0, 32'h0, 32'h0, 0, 32'hA4, 0);
    v(1, 16'h0041, 0, 32'h0, 32'h0, 1, 32'hB, 0);
    // set up pending writes for the reset case
    v(0, 16'h0000, 1, 32'h0000_0044, 32'h77, 0, 32'hB, 1);
    v(0, 16'h0000, 0, 32'h0, 32'h0, 0, 32'hB, 0);
    v(1, 16'h000C, 1, 32'h0000_0044, 32'h99, 1, 32'hDEADBEEF, 1);
    v(1, 16'h000C, 1, 32'h0000_0048, 32'h1, 1, 32'hDEADBEEF, 2);
    v(1, 16'h000C, 1, 32'h0000_004C, 32'h2, 1, 32'hDEADBEEF, 3);
    run_vecs();

    // async reset between edges discards pending writes
    #2;
    reset_n = 1'b0;
    #1;
    check("async count", 32'(wb_count), 32'd0);
    check("async valid", 32'(rd_ram_valid), 32'd0);
    check("async data", rd_ram_data, 32'd0);
    check("async full", 32'(wb_full), 32'd0);
    #1;
    reset_n = 1'b1;
    @(posedge clk);
    #1;

    v(1, 16'h0044, 0, 32'h0, 32'h0, 1, 32'h77, 0);
    v(0, 16'h0000, 0, 32'h0, 32'h0, 0, 32'h77, 0);
    v(1, 16'h0044, 0, 32'h0, 32'h0, 1, 32'h77, 0);
    run_vecs();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
